// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-issue instruction fetch stage.
// Holds the PC and presents one registered fetch packet to decode with a
// valid/ready handshake. Misaligned or out-of-range fetches become exception
// packets that park the stage until a redirect arrives.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          MEM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc_addr,
  input  logic [31:0] instruction,
  input  logic        mem_exc_en,
  input  logic [3:0]  mem_exc_code,
  input  logic [63:0] mem_exc_val,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_exc_en,
  output logic [3:0]  if_exc_code,
  output logic [63:0] if_exc_val
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [61:0] MEM_LIMIT = 62'(MEM_WORDS);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic        r_if_valid;
  logic [63:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic        r_if_exc_en;
  logic [3:0]  r_if_exc_code;
  logic [63:0] r_if_exc_val;

  logic w_misal;
  logic w_oor;
  logic w_exc;
  logic w_capture;

  // The fault is reported as the PC itself; the memory's own cause/value
  // fields are not forwarded, so they are deliberately left unused here.
  logic w_unused_mem_exc;
  assign w_unused_mem_exc = ^{mem_exc_code, mem_exc_val};

  // Classify the current PC and decide whether a new packet is taken this edge.
  always_comb begin
    w_misal   = (r_pc[1:0] != 2'b00);
    w_oor     = !w_misal && ((r_pc[63:2] >= MEM_LIMIT) || mem_exc_en);
    w_exc     = w_misal || w_oor;
    w_capture = 1'b0;
    case (r_state)
      FETCH:   w_capture = !r_if_valid || if_ready;
      HOLD:    w_capture = if_ready;
      default: w_capture = 1'b0;
    endcase
  end

  // Fetch FSM: reset > redirect > capture/hold/fault handling.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_pc       <= 64'h0;
      r_if_instr    <= NOP;
      r_if_exc_en   <= 1'b0;
      r_if_exc_code <= 4'd0;
      r_if_exc_val  <= 64'h0;
    end else if (redirect_en) begin
      // Drop whatever is pending, even if decode is accepting it this cycle.
      r_state     <= FETCH;
      r_pc        <= redirect_pc;
      r_if_valid  <= 1'b0;
      r_if_exc_en <= 1'b0;
    end else begin
      case (r_state)
        FETCH, HOLD: begin
          if (w_capture) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_pc;
            if (w_exc) begin
              // Exception packet: PC stays put and the stage parks in FAULT.
              r_if_instr    <= NOP;
              r_if_exc_en   <= 1'b1;
              r_if_exc_code <= w_misal ? 4'd0 : 4'd1;
              r_if_exc_val  <= r_pc;
              r_state       <= FAULT;
            end else begin
              r_if_instr    <= instruction;
              r_if_exc_en   <= 1'b0;
              r_if_exc_code <= 4'd0;
              r_if_exc_val  <= 64'h0;
              r_pc          <= r_pc + 64'd4;
              r_state       <= FETCH;
            end
          end else begin
            // Packet valid and stalled: freeze everything.
            r_state <= HOLD;
          end
        end
        FAULT: begin
          if (r_if_valid && if_ready) r_if_valid <= 1'b0;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign pc_addr     = r_pc;
  assign if_valid    = r_if_valid;
  assign if_pc       = r_if_pc;
  assign if_instr    = r_if_instr;
  assign if_exc_en   = r_if_exc_en;
  assign if_exc_code = r_if_exc_code;
  assign if_exc_val  = r_if_exc_val;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning PC loaded on reset.
REQ-002 SHALL have parameter MEM_WORDS, default 2048, meaning instruction memory depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port pc_addr  output  64  fetch address driven to instruction memory; equals internal PC register.
REQ-006 SHALL have port instruction  input  32  combinational read data from instruction memory.
REQ-007 SHALL have port mem_exc_en  input  1  memory access-fault flag for pc_addr.
REQ-008 SHALL have port mem_exc_code  input  4  memory fault cause.
REQ-009 SHALL have port mem_exc_val  input  64  memory fault value.
REQ-010 SHALL have port redirect_en  input  1  branch/trap redirect request.
REQ-011 SHALL have port redirect_pc  input  64  redirect target.
REQ-012 SHALL have port if_valid  output  1  fetch packet valid to decode.
REQ-013 SHALL have port if_ready  input  1  decode accepts the packet this cycle.
REQ-014 SHALL have port if_pc  output  64  PC of the packet.
REQ-015 SHALL have port if_instr  output  32  instruction of the packet.
REQ-016 SHALL have port if_exc_en  output  1  packet carries an exception.
REQ-017 SHALL have port if_exc_code  output  4  exception cause.
REQ-018 SHALL have port if_exc_val  output  64  exception value (MTVAL).

Function
REQ-019 SHALL implement states FETCH, HOLD and FAULT; all if_* outputs registered.
REQ-020 Packet transfer SHALL occur on an edge where if_valid=1 and if_ready=1.
REQ-021 In FETCH, when if_valid=0 or if_ready=1: capture {PC, instruction, exception} into if_*, set if_valid=1, PC<=PC+4 (64-bit wrap); one-cycle latency from pc_addr to if_*.
REQ-022 When if_valid=1 and if_ready=0: go to HOLD; all if_* and PC stable until if_ready=1, then resume FETCH on that edge, capturing the next packet.
REQ-023 Misaligned: PC[1:0]!=0 at capture SHALL produce if_exc_en=1, code 4'd0, val=PC, if_instr=32'h00000013; mem_exc_* ignored.
REQ-024 Out of range: PC[63:2]>=MEM_WORDS (aligned) or mem_exc_en=1 SHALL produce if_exc_en=1, code 4'd1, val=PC, if_instr=32'h00000013.
REQ-025 After capturing any exception packet: go to FAULT; PC not incremented; once that packet transfers, if_valid<=0; no further capture until redirect.
REQ-026 Redirect (redirect_en=1) SHALL have top priority in every state: next edge PC<=redirect_pc, if_valid<=0, if_exc_en<=0, state<=FETCH; the pending packet is dropped even if if_ready=1 that cycle.
REQ-027 Redirect and the capture conditions of REQ-021 in the same cycle: redirect wins; no capture from old PC.
REQ-028 pc_addr SHALL always equal PC, including in HOLD and FAULT.
REQ-029 PC+4 from 64'hFFFF_FFFF_FFFF_FFFC SHALL wrap to 0; resulting fault handled per REQ-024.

Reset
REQ-030 With rst=0 at an edge: PC<=RESET_PC, state<=FETCH, if_valid<=0, if_pc<=0, if_instr<=32'h00000013, if_exc_en<=0, if_exc_code<=0, if_exc_val<=0.
REQ-031 Reset SHALL override redirect_en and any in-flight HOLD/FAULT state; first packet (PC=RESET_PC) valid on the second edge after rst rises.

Verification
REQ-032 Reset release, if_ready=1, mem words 0..3 = 0x13,0x93,0x113,0x193 -> if_pc 0,4,8,12 on consecutive cycles with matching if_instr.
REQ-033 if_ready=0 for 3 cycles while if_pc=8 -> if_pc/if_instr stable for 3 cycles, pc_addr=12; on if_ready=1 next packet if_pc=12, no skip or duplicate.
REQ-034 redirect_en=1, redirect_pc=0x40 while if_ready=0 at if_pc=4 -> next cycle if_valid=0, pc_addr=0x40; following cycle if_pc=0x40.
REQ-035 redirect_pc=0x2000 (MEM_WORDS=2048) -> one packet if_exc_en=1, code 1, val 0x2000, instr 0x13; then if_valid=0, pc_addr held 0x2000 until redirect.
REQ-036 redirect_pc=0x42 -> packet code 0, val 0x42; FAULT; redirect to 0x0 recovers with if_pc=0.
REQ-037 rst=0 asserted during HOLD with redirect_en=1 -> next cycle if_valid=0, pc_addr=RESET_PC.
